// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the QSPI bus arbiter and its address decoders.
package qspi_arb_pkg;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_t;
   typedef enum logic [1:0] {TGT_FLASH, TGT_PSRAM, TGT_NONE} target_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // Each memory window spans 16 MiB, so the engine offset is 24 bits wide.
   localparam int WIN_W = 24;

endpackage

// File: rtl/qspi_addr_decode.sv
// Maps the upper address byte of a request onto the flash window, the PSRAM window, or nothing.
module qspi_addr_decode
   import qspi_arb_pkg::*;
#(
   parameter logic [31-WIN_W:0] FLASH_PAGE = 8'h00,
   parameter logic [31-WIN_W:0] PSRAM_PAGE = 8'h01
) (
   input  logic [31-WIN_W:0] addr_hi,
   output target_t           tgt
);

   always_comb begin
      tgt = TGT_NONE;
      if (addr_hi == FLASH_PAGE) begin
         tgt = TGT_FLASH;
      end else if (addr_hi == PSRAM_PAGE) begin
         tgt = TGT_PSRAM;
      end
   end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Shares one QSPI engine between the instruction-fetch and data ports, with a chip-select
// gap after every transaction and a bound on how long fetch may starve a pending data request.
module qspi_bus_arbiter
   import qspi_arb_pkg::*;
#(
   parameter logic [31:0] FLASH_BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] PSRAM_BASE_ADDR = 32'h0100_0000,
   parameter int unsigned MIN_GAP         = 2,
   parameter int unsigned STARVE_LIMIT    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_wdata,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        eng_start,
   output logic        eng_sel,
   output logic        eng_we,
   output logic [23:0] eng_addr,
   output logic [1:0]  eng_size,
   output logic [31:0] eng_wdata,
   input  logic        eng_done,
   input  logic [31:0] eng_rdata
);

   localparam logic [3:0] GAP_LOAD   = 4'(MIN_GAP - 1);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t            state, state_nxt;
   target_t           if_tgt, d_tgt, win_tgt;
   logic              grant_d;
   logic              pick_any, pick_d, pick_err;
   logic [WIN_W-1:0]  win_off;
   logic [3:0]        starve_cnt;
   logic [3:0]        gap_cnt;

   qspi_addr_decode #(
      .FLASH_PAGE (FLASH_BASE_ADDR[31:WIN_W]),
      .PSRAM_PAGE (PSRAM_BASE_ADDR[31:WIN_W])
   ) u_if_decode (
      .addr_hi (if_addr[31:WIN_W]),
      .tgt     (if_tgt)
   );

   qspi_addr_decode #(
      .FLASH_PAGE (FLASH_BASE_ADDR[31:WIN_W]),
      .PSRAM_PAGE (PSRAM_BASE_ADDR[31:WIN_W])
   ) u_d_decode (
      .addr_hi (d_addr[31:WIN_W]),
      .tgt     (d_tgt)
   );

   // Fetch wins unless it has already been granted STARVE_LIMIT times over a waiting data request.
   always_comb begin
      pick_any  = if_req | d_req;
      pick_d    = d_req & (~if_req | (starve_cnt >= STARVE_MAX));
      win_tgt   = pick_d ? d_tgt : if_tgt;
      win_off   = pick_d ? d_addr[WIN_W-1:0] : if_addr[WIN_W-1:0];
      pick_err  = (win_tgt == TGT_NONE) | (pick_d & d_we & (win_tgt == TGT_FLASH));
      state_nxt = state;
      case (state)
         IDLE:    if (pick_any) state_nxt = pick_err ? RESP : ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (eng_done) state_nxt = RESP;
         RESP:    state_nxt = GAP;
         GAP:     if (gap_cnt == 4'd0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_ready   <= 1'b0;
         d_ready    <= 1'b0;
         if_err     <= 1'b0;
         d_err      <= 1'b0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         eng_start  <= 1'b0;
         eng_sel    <= 1'b0;
         eng_we     <= 1'b0;
         eng_addr   <= '0;
         eng_size   <= '0;
         eng_wdata  <= '0;
         grant_d    <= 1'b0;
         starve_cnt <= '0;
         gap_cnt    <= '0;
      end else begin
         if_ready  <= 1'b0;
         d_ready   <= 1'b0;
         eng_start <= 1'b0;
         case (state)
            IDLE: begin
               if (!d_req || pick_d) begin
                  starve_cnt <= '0;
               end else if (starve_cnt < STARVE_MAX) begin
                  starve_cnt <= starve_cnt + 4'd1;
               end
               if (pick_any) begin
                  grant_d <= pick_d;
                  if (pick_err) begin
                     // Refused requests answer straight away and never touch the bus.
                     if_ready <= ~pick_d;
                     if_err   <= ~pick_d;
                     d_ready  <= pick_d;
                     d_err    <= pick_d;
                  end else begin
                     eng_start <= 1'b1;
                     eng_sel   <= (win_tgt == TGT_PSRAM);
                     eng_we    <= pick_d & d_we;
                     eng_addr  <= win_off;
                     eng_size  <= pick_d ? d_size : SIZE_WORD;
                     eng_wdata <= pick_d ? d_wdata : '0;
                  end
               end
            end
            WAIT: begin
               if (eng_done) begin
                  if (grant_d) begin
                     d_ready <= 1'b1;
                     d_err   <= 1'b0;
                     d_rdata <= eng_rdata;
                  end else begin
                     if_ready <= 1'b1;
                     if_err   <= 1'b0;
                     if_rdata <= eng_rdata;
                  end
               end
            end
            RESP: begin
               if_err  <= 1'b0;
               d_err   <= 1'b0;
               gap_cnt <= GAP_LOAD;
            end
            GAP: begin
               if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Bench for qspi_bus_arbiter: directed scenarios plus randomized traffic against a cycle-level reference.
module tb_qspi_bus_arbiter;
   import qspi_arb_pkg::*;

   localparam int MIN_GAP      = 3;
   localparam int STARVE_LIMIT = 4;

   logic        clk, rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready, if_err;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic [1:0]  d_size;
   logic        d_ready, d_err;
   logic [31:0] d_rdata;
   logic        eng_start, eng_sel, eng_we;
   logic [23:0] eng_addr;
   logic [1:0]  eng_size;
   logic [31:0] eng_wdata;
   logic        eng_done;
   logic [31:0] eng_rdata;

   qspi_bus_arbiter #(
      .MIN_GAP      (MIN_GAP),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ready  (if_ready),
      .if_rdata  (if_rdata),
      .if_err    (if_err),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_size    (d_size),
      .d_wdata   (d_wdata),
      .d_ready   (d_ready),
      .d_rdata   (d_rdata),
      .d_err     (d_err),
      .eng_start (eng_start),
      .eng_sel   (eng_sel),
      .eng_we    (eng_we),
      .eng_addr  (eng_addr),
      .eng_size  (eng_size),
      .eng_wdata (eng_wdata),
      .eng_done  (eng_done),
      .eng_rdata (eng_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end, got timeout required finish");
      $fatal(1);
   end

   int per;
   int n_checks, n_errors;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         if (n_errors <= 60)
            $display("FAIL %s: got 0x%08h required 0x%08h (period %0d)", tag, got, exp, per);
      end
   endtask

   // Reference state: the arbiter is free from period m_free_at onward when not waiting on the engine.
   int          m_free_at, m_starve;
   bit          m_busy, m_win_d;
   logic        m_sel, m_we;
   logic [23:0] m_addr;
   logic [1:0]  m_size;
   logic [31:0] m_wdata;
   bit          nx_if_rdy, nx_d_rdy, nx_start, nx_err;
   logic [31:0] nx_rdata;
   bit          e_if_rdy, e_d_rdy, e_start, e_err;
   logic [31:0] e_rdata;

   bit          eng_busy, have_done, stray_en, force_en, keep_if, keep_d, rand_en;
   int          done_at, last_done, eng_lat, n_starts, last_d_rdy_per, last_if_rdy_per;
   logic [31:0] force_rd;
   byte         order[$];
   logic [1:0]  sizes [3];

   function automatic int ref_tgt(input logic [31:0] a);
      if (a[31:24] == 8'h00) return 0;
      if (a[31:24] == 8'h01) return 1;
      return 2;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom;
      case ($urandom_range(0, 4))
         0, 1:    a[31:24] = 8'h00;
         2, 3:    a[31:24] = 8'h01;
         default: a[31:24] = 8'h02 + 8'($urandom_range(0, 200));
      endcase
      return a;
   endfunction

   // Predicts what the arbiter shows in the next period, given this period's inputs.
   task automatic model();
      bit wd, er;
      int t;
      nx_if_rdy = 0; nx_d_rdy = 0; nx_start = 0; nx_err = 0; nx_rdata = '0;
      if (!m_busy && per >= m_free_at) begin
         if (!d_req) m_starve = 0;
         if (if_req || d_req) begin
            wd = d_req && (!if_req || m_starve >= STARVE_LIMIT);
            if (wd) m_starve = 0;
            else if (d_req) m_starve++;
            t  = ref_tgt(wd ? d_addr : if_addr);
            er = (t == 2) || (wd && d_we && t == 0);
            m_win_d = wd;
            if (er) begin
               nx_err = 1; nx_if_rdy = !wd; nx_d_rdy = wd;
               m_free_at = per + 2 + MIN_GAP;
            end else begin
               nx_start = 1; m_busy = 1;
               m_sel   = (t == 1);
               m_we    = wd && d_we;
               m_addr  = wd ? d_addr[23:0] : if_addr[23:0];
               m_size  = wd ? d_size : 2'd2;
               m_wdata = wd ? d_wdata : 32'd0;
            end
         end
      end else if (m_busy && eng_done) begin
         m_busy = 0; nx_if_rdy = !m_win_d; nx_d_rdy = m_win_d; nx_rdata = eng_rdata;
         m_free_at = per + 2 + MIN_GAP;
      end
   endtask

   task automatic rand_stim();
      if (!if_req && $urandom_range(0, 3) == 0) begin
         if_req = 1; if_addr = rand_addr() & ~32'h3;
      end
      if (!d_req && $urandom_range(0, 3) == 0) begin
         d_req = 1; d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1));
         d_size = sizes[$urandom_range(0, 2)]; d_wdata = $urandom;
      end
      eng_lat = $urandom_range(1, 6);
   endtask

   task automatic step();
      model();
      @(negedge clk);
      per++;
      e_if_rdy = nx_if_rdy; e_d_rdy = nx_d_rdy; e_start = nx_start; e_err = nx_err; e_rdata = nx_rdata;
      chk("if_ready", 32'(if_ready), 32'(e_if_rdy));
      chk("d_ready", 32'(d_ready), 32'(e_d_rdy));
      chk("eng_start", 32'(eng_start), 32'(e_start));
      if (e_start) begin
         chk("eng_sel", 32'(eng_sel), 32'(m_sel));
         chk("eng_we", 32'(eng_we), 32'(m_we));
         chk("eng_addr", 32'(eng_addr), 32'(m_addr));
         chk("eng_size", 32'(eng_size), 32'(m_size));
         chk("eng_wdata", eng_wdata, m_wdata);
      end
      if (e_if_rdy) begin
         chk("if_err", 32'(if_err), 32'(e_err));
         if (!e_err) chk("if_rdata", if_rdata, e_rdata);
      end
      if (e_d_rdy) begin
         chk("d_err", 32'(d_err), 32'(e_err));
         if (!e_err) chk("d_rdata", d_rdata, e_rdata);
      end
      if (if_ready) begin order.push_back(8'h46); last_if_rdy_per = per; end
      if (d_ready) begin order.push_back(8'h44); last_d_rdy_per = per; end
      if (eng_start) begin
         n_starts++;
         if (have_done) chk("cs_gap", 32'(per - last_done - 1 >= MIN_GAP), 32'd1);
         eng_busy = 1; done_at = per + eng_lat;
      end
      if (if_ready && !keep_if) if_req = 0;
      if (d_ready && !keep_d) d_req = 0;
      eng_done = 0; eng_rdata = $urandom;
      if (eng_busy && per == done_at) begin
         chk("eng_addr_hold", 32'(eng_addr), 32'(m_addr));
         eng_done = 1; eng_busy = 0; have_done = 1; last_done = per;
         if (force_en) eng_rdata = force_rd;
      end else if (!eng_busy && stray_en && $urandom_range(0, 15) == 0) begin
         eng_done = 1;
      end
      if (rand_en) rand_stim();
   endtask

   task automatic wait_quiet(input int budget);
      int n;
      n = 0;
      while ((if_req || d_req || m_busy || per < m_free_at) && n < budget) begin
         step();
         n++;
      end
      chk("quiet_reached", 32'(n < budget), 32'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_if_ready"}, 32'(if_ready), 0);
      chk({tag, "_d_ready"}, 32'(d_ready), 0);
      chk({tag, "_if_err"}, 32'(if_err), 0);
      chk({tag, "_d_err"}, 32'(d_err), 0);
      chk({tag, "_eng_start"}, 32'(eng_start), 0);
      chk({tag, "_eng_sel"}, 32'(eng_sel), 0);
      chk({tag, "_eng_we"}, 32'(eng_we), 0);
      chk({tag, "_eng_addr"}, 32'(eng_addr), 0);
      chk({tag, "_eng_size"}, 32'(eng_size), 0);
      chk({tag, "_eng_wdata"}, eng_wdata, 0);
      chk({tag, "_if_rdata"}, if_rdata, 0);
      chk({tag, "_d_rdata"}, d_rdata, 0);
   endtask

   task automatic mid_reset();
      #2 rst_n = 0;
      #1 chk_reset_outputs("mid_rst");
      if_req = 0; d_req = 0; eng_done = 0; eng_busy = 0; have_done = 0;
      repeat (2) begin
         @(negedge clk);
         per++;
      end
      rst_n = 1;
      m_busy = 0; m_starve = 0; m_free_at = per;
      nx_if_rdy = 0; nx_d_rdy = 0; nx_start = 0; nx_err = 0;
   endtask

   initial begin
      string exp_order;
      int    req_per, n;
      sizes = '{SIZE_BYTE, SIZE_HALF, SIZE_WORD};
      rst_n = 0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_size = '0;
      d_wdata = '0; eng_done = 0; eng_rdata = '0;
      n_checks = 0; n_errors = 0; per = 0; m_free_at = 0; m_starve = 0; m_busy = 0;
      eng_busy = 0; have_done = 0; stray_en = 0; force_en = 0; keep_if = 0; keep_d = 0;
      rand_en = 0; eng_lat = 4; n_starts = 0; force_rd = '0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("rst");
      rst_n = 1;
      repeat (3) step();

      // Single fetch from flash with an 8-cycle engine.
      order.delete(); eng_lat = 8; force_en = 1; force_rd = 32'h1300_0000;
      if_req = 1; if_addr = 32'h0000_0100;
      wait_quiet(100);
      chk("fetch_ready_count", 32'(order.size()), 1);
      force_en = 0;

      // Word write to PSRAM.
      order.delete(); eng_lat = 3;
      d_req = 1; d_we = 1; d_addr = 32'h0100_0040; d_wdata = 32'hDEAD_BEEF; d_size = 2'd2;
      wait_quiet(100);
      chk("dwrite_ready_count", 32'(order.size()), 1);

      // Write to flash is refused without touching the bus.
      n_starts = 0; req_per = per;
      d_req = 1; d_we = 1; d_addr = 32'h0000_0010;
      wait_quiet(50);
      chk("flash_write_latency", 32'(last_d_rdy_per - req_per), 1);
      chk("flash_write_starts", 32'(n_starts), 0);
      d_we = 0;

      // Fetch outside both windows.
      n_starts = 0; req_per = per;
      if_req = 1; if_addr = 32'h0200_0000;
      wait_quiet(50);
      chk("bad_fetch_latency", 32'(last_if_rdy_per - req_per), 1);
      chk("bad_fetch_starts", 32'(n_starts), 0);

      // Both ports held continuously: data gets one grant after every STARVE_LIMIT fetches.
      order.delete(); keep_if = 1; keep_d = 1; eng_lat = 2;
      if_req = 1; if_addr = 32'h0000_0200;
      d_req = 1; d_we = 0; d_addr = 32'h0100_0080; d_size = 2'd2;
      n = 0;
      while (order.size() < 10 && n < 600) begin
         step();
         n++;
      end
      keep_if = 0; keep_d = 0; if_req = 0; d_req = 0;
      wait_quiet(50);
      chk("starve_grants", 32'(order.size()), 10);
      exp_order = "FFFFDFFFFD";
      for (int i = 0; i < 10 && i < order.size(); i++)
         chk($sformatf("grant_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));

      // Back-to-back fetches exercise the chip-select gap.
      order.delete(); keep_if = 1; eng_lat = 3;
      if_req = 1; if_addr = 32'h0000_0300;
      n = 0;
      while (order.size() < 3 && n < 200) begin
         step();
         n++;
      end
      keep_if = 0; if_req = 0;
      wait_quiet(50);
      chk("gap_fetches", 32'(order.size()), 3);

      // Reset while waiting on the engine, then a fresh fetch.
      n_starts = 0; eng_lat = 10;
      if_req = 1; if_addr = 32'h0100_0ABC;
      n = 0;
      while (n_starts == 0 && n < 20) begin
         step();
         n++;
      end
      step(); step();
      mid_reset();
      order.delete(); eng_lat = 2;
      if_req = 1; if_addr = 32'h0000_0400;
      wait_quiet(100);
      chk("post_reset_fetch", 32'(order.size()), 1);

      // Randomized mixed traffic with stray done pulses.
      rand_en = 1; stray_en = 1;
      repeat (3000) step();
      rand_en = 0; stray_en = 0;
      wait_quiet(500);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
